// File: rtl/onehot_decoder_3to8_if.sv
// Handshake and decoded-output bundle for onehot_decoder_3to8.
// master drives the encoded index; slave is the decoder.
interface onehot_decoder_3to8_if;
  logic       in_valid;
  logic [2:0] in_index;
  logic       in_ready;
  logic [7:0] out;
  logic       out_valid;
  logic       done;

  modport master (
    output in_valid, in_index,
    input  in_ready, out, out_valid, done
  );

  modport slave (
    input  in_valid, in_index,
    output in_ready, out, out_valid, done
  );
endinterface

// File: rtl/onehot_decoder_3to8.sv
// Registered 3-to-8 one-hot decoder with valid/ready input and a fixed hold window.
// Define ONEHOT_DEC_QUEUE_EN to add a one-entry pending register for back-to-back windows.
module onehot_decoder_3to8 #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = $clog2(HOLD_CYCLES) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  onehot_decoder_3to8_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       out_q, out_d;
  logic             ready_s;
  logic             accept_s;
  logic             last_s;

`ifdef ONEHOT_DEC_QUEUE_EN
  logic       pend_vld_q, pend_vld_d;
  logic [2:0] pend_idx_q, pend_idx_d;
`endif

  function automatic logic [7:0] decode_onehot(input logic [2:0] idx);
    decode_onehot = 8'h01 << idx;
  endfunction

`ifdef ONEHOT_DEC_QUEUE_EN
  assign ready_s = ~pend_vld_q;
`else
  assign ready_s = (state_q == ST_IDLE);
`endif

  assign accept_s = bus.in_valid & ready_s;
  assign last_s   = (state_q == ST_HOLD) && (cnt_q == CNT_W'(0));

  // Next-state: window start, countdown, and hand-over at the end of each window
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
`ifdef ONEHOT_DEC_QUEUE_EN
    pend_vld_d = pend_vld_q;
    pend_idx_d = pend_idx_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          out_d   = decode_onehot(bus.in_index);
          cnt_d   = CNT_RELOAD;
          state_d = ST_HOLD;
        end else begin
          out_d = 8'h00;
          cnt_d = CNT_W'(0);
        end
      end
      ST_HOLD: begin
        if (!last_s) begin
          cnt_d = cnt_q - CNT_W'(1);
`ifdef ONEHOT_DEC_QUEUE_EN
          if (accept_s) begin
            pend_vld_d = 1'b1;
            pend_idx_d = bus.in_index;
          end else begin
            pend_vld_d = pend_vld_q;
          end
`endif
        end else begin
`ifdef ONEHOT_DEC_QUEUE_EN
          // Pending entry wins over a same-cycle accept, which then refills pending
          if (pend_vld_q) begin
            out_d      = decode_onehot(pend_idx_q);
            cnt_d      = CNT_RELOAD;
            pend_vld_d = accept_s;
            pend_idx_d = accept_s ? bus.in_index : pend_idx_q;
          end else if (accept_s) begin
            out_d = decode_onehot(bus.in_index);
            cnt_d = CNT_RELOAD;
          end else begin
            out_d   = 8'h00;
            state_d = ST_IDLE;
          end
`else
          out_d   = 8'h00;
          state_d = ST_IDLE;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_W'(0);
        out_d   = 8'h00;
      end
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_W'(0);
      out_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

`ifdef ONEHOT_DEC_QUEUE_EN
  // One-entry pending register
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_vld_q <= 1'b0;
      pend_idx_q <= 3'd0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_idx_q <= pend_idx_d;
    end
  end
`endif

  assign bus.in_ready  = ready_s;
  assign bus.out       = out_q;
  assign bus.out_valid = |out_q;
  assign bus.done      = last_s;

endmodule

// File: tb/tb_onehot_decoder_3to8.sv
// Bench for onehot_decoder_3to8: vector tables, hand-written window sequences and
// randomized traffic against a window/queue reference model, on HOLD_CYCLES 4, 1 and 2.
module tb_onehot_decoder_3to8;

`ifdef ONEHOT_DEC_QUEUE_EN
  localparam bit QUEUE = 1'b1;
`else
  localparam bit QUEUE = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  onehot_decoder_3to8_if if4 ();
  onehot_decoder_3to8_if if1 ();
  onehot_decoder_3to8_if if2 ();

  onehot_decoder_3to8 #(.HOLD_CYCLES(4)) u_dut4 (.clk(clk), .reset(reset), .bus(if4));
  onehot_decoder_3to8 #(.HOLD_CYCLES(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
  onehot_decoder_3to8 #(.HOLD_CYCLES(2)) u_dut2 (.clk(clk), .reset(reset), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] idx;
    logic [7:0] o;
    logic       r;
    logic       d;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] ex_o[16];
  logic       ex_r[16];
  logic       ex_d[16];
  logic [2:0] seq_ids[3];

  // Reference model: the line being shown, cycles left in its window, waiting indices
  int m_cur;
  int m_left;
  int m_hold;
  int m_pend[$];

  function automatic logic [7:0] line(input int k);
    line = 8'(2 ** k);
  endfunction

  function automatic logic m_ready();
    m_ready = QUEUE ? (m_pend.size() == 0) : (m_cur < 0);
  endfunction

  task automatic m_reset();
    m_cur  = -1;
    m_left = 0;
    m_pend.delete();
  endtask

  task automatic m_step(input logic acc, input int idx);
    if (m_cur < 0) begin
      if (acc) begin
        m_cur  = idx;
        m_left = m_hold;
      end
    end else if (m_left > 1) begin
      m_left = m_left - 1;
      if (acc) m_pend.push_back(idx);
    end else if (m_pend.size() > 0) begin
      m_cur  = m_pend.pop_front();
      m_left = m_hold;
      if (acc) m_pend.push_back(idx);
    end else if (acc) begin
      m_cur  = idx;
      m_left = m_hold;
    end else begin
      m_cur = -1;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%02h required=%02h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [2:0] idx);
    case (sel)
      0: begin if4.in_valid = v; if4.in_index = idx; end
      1: begin if1.in_valid = v; if1.in_index = idx; end
      default: begin if2.in_valid = v; if2.in_index = idx; end
    endcase
  endtask

  task automatic check_cycle(input string tag, input int sel, input logic [7:0] eo,
                             input logic er, input logic ed);
    logic [7:0] o;
    logic r, d, ov;
    case (sel)
      0: begin o = if4.out; r = if4.in_ready; d = if4.done; ov = if4.out_valid; end
      1: begin o = if1.out; r = if1.in_ready; d = if1.done; ov = if1.out_valid; end
      default: begin o = if2.out; r = if2.in_ready; d = if2.done; ov = if2.out_valid; end
    endcase
    chk({tag, " out"}, o, eo);
    chk({tag, " in_ready"}, 8'(r), 8'(er));
    chk({tag, " done"}, 8'(d), 8'(ed));
    chk({tag, " out_valid"}, 8'(ov), 8'(|eo));
  endtask

  task automatic run_table(input string name, input int sel);
    for (int i = 0; i < tbl.size(); i++) begin
      check_cycle($sformatf("%s c%0d", name, i), sel, tbl[i].o, tbl[i].r, tbl[i].d);
      drive(sel, tbl[i].v, tbl[i].idx);
      @(negedge clk);
    end
    drive(sel, 1'b0, 3'd0);
  endtask

  task automatic clear_ex();
    for (int c = 0; c < 16; c++) begin
      ex_o[c] = 8'h00; ex_r[c] = 1'b1; ex_d[c] = 1'b0;
    end
  endtask

  task automatic set_ex(input int c, input logic [7:0] o, input logic r, input logic d);
    ex_o[c] = o; ex_r[c] = r; ex_d[c] = d;
  endtask

  // Source presents seq_ids back to back, holding each until the expected ready takes it
  task automatic run_seq(input string name, input int sel);
    int k = 0;
    logic v;
    for (int c = 0; c < 16; c++) begin
      check_cycle($sformatf("%s c%0d", name, c), sel, ex_o[c], ex_r[c], ex_d[c]);
      v = (k < 3);
      drive(sel, v, seq_ids[k % 3]);
      @(negedge clk);
      if (v && ex_r[c]) k++;
    end
    drive(sel, 1'b0, 3'd0);
  endtask

  task automatic run_random(input int sel, input int hold, input int ncyc);
    logic v = 1'b0;
    logic [2:0] idx = 3'd0;
    logic rb, acc, holding;
    logic [7:0] eo;
    reset = 1'b1;
    drive(sel, 1'b0, 3'd0);
    @(negedge clk);
    reset  = 1'b0;
    m_hold = hold;
    m_reset();
    holding = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      eo = (m_cur < 0) ? 8'h00 : line(m_cur);
      check_cycle($sformatf("rand h%0d c%0d", hold, c), sel, eo, m_ready(),
                  (m_cur >= 0) && (m_left == 1));
      if (!holding) begin
        v   = ($urandom_range(0, 9) < 6);
        idx = 3'($urandom_range(0, 7));
      end
      rb    = ($urandom_range(0, 39) == 0);
      reset = rb;
      drive(sel, v, idx);
      acc = v && !rb && m_ready();
      @(negedge clk);
      if (rb) m_reset();
      else m_step(acc, int'(idx));
      holding = v && !acc;
    end
    reset = 1'b0;
    drive(sel, 1'b0, 3'd0);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    for (int s = 0; s < 3; s++) drive(s, 1'b1, 3'd3);

    // Reset held two edges with in_valid high: nothing may be accepted
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) check_cycle($sformatf("reset s%0d c%0d", s, c), s, 8'h00, 1'b1, 1'b0);
    end
    reset = 1'b0;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 3'd0);
    @(negedge clk);
    for (int s = 0; s < 3; s++) check_cycle($sformatf("post_reset s%0d", s), s, 8'h00, 1'b1, 1'b0);

    // Single decode of index 5, HOLD_CYCLES=4
    tbl.delete();
    tbl.push_back('{1'b1, 3'd5, 8'h00, 1'b1, 1'b0});
    for (int c = 1; c <= 4; c++) tbl.push_back('{1'b0, 3'd0, 8'h20, QUEUE, (c == 4)});
    tbl.push_back('{1'b0, 3'd0, 8'h00, 1'b1, 1'b0});
    run_table("single", 0);

    // Sweep 0..7 presented continuously, HOLD_CYCLES=1
    tbl.delete();
    if (QUEUE) begin
      tbl.push_back('{1'b1, 3'd0, 8'h00, 1'b1, 1'b0});
      for (int j = 1; j <= 8; j++) tbl.push_back('{(j < 8), 3'(j), line(j - 1), 1'b1, 1'b1});
    end else begin
      for (int k = 0; k < 8; k++) begin
        tbl.push_back('{1'b1, 3'(k), 8'h00, 1'b1, 1'b0});
        tbl.push_back('{(k < 7), 3'(k + 1), line(k), 1'b0, 1'b1});
      end
    end
    tbl.push_back('{1'b0, 3'd0, 8'h00, 1'b1, 1'b0});
    run_table("sweep", 1);

    // Indices 3,6,1 back to back, HOLD_CYCLES=2
    seq_ids[0] = 3'd3; seq_ids[1] = 3'd6; seq_ids[2] = 3'd1;
    clear_ex();
    if (QUEUE) begin
      set_ex(1, 8'h08, 1'b1, 1'b0); set_ex(2, 8'h08, 1'b0, 1'b1);
      set_ex(3, 8'h40, 1'b1, 1'b0); set_ex(4, 8'h40, 1'b0, 1'b1);
      set_ex(5, 8'h02, 1'b1, 1'b0); set_ex(6, 8'h02, 1'b1, 1'b1);
    end else begin
      set_ex(1, 8'h08, 1'b0, 1'b0); set_ex(2, 8'h08, 1'b0, 1'b1);
      set_ex(4, 8'h40, 1'b0, 1'b0); set_ex(5, 8'h40, 1'b0, 1'b1);
      set_ex(7, 8'h02, 1'b0, 1'b0); set_ex(8, 8'h02, 1'b0, 1'b1);
    end
    run_seq("b2b", 2);

    // Backpressure: 7, 2, then 4 held until it is taken, HOLD_CYCLES=4
    seq_ids[0] = 3'd7; seq_ids[1] = 3'd2; seq_ids[2] = 3'd4;
    clear_ex();
    if (QUEUE) begin
      set_ex(1, 8'h80, 1'b1, 1'b0);
      for (int c = 2; c <= 3; c++) set_ex(c, 8'h80, 1'b0, 1'b0);
      set_ex(4, 8'h80, 1'b0, 1'b1);
      set_ex(5, 8'h04, 1'b1, 1'b0);
      for (int c = 6; c <= 7; c++) set_ex(c, 8'h04, 1'b0, 1'b0);
      set_ex(8, 8'h04, 1'b0, 1'b1);
      for (int c = 9; c <= 12; c++) set_ex(c, 8'h10, 1'b1, (c == 12));
    end else begin
      for (int c = 1; c <= 4; c++) set_ex(c, 8'h80, 1'b0, (c == 4));
      for (int c = 6; c <= 9; c++) set_ex(c, 8'h04, 1'b0, (c == 9));
      for (int c = 11; c <= 14; c++) set_ex(c, 8'h10, 1'b0, (c == 14));
    end
    run_seq("bpress", 0);

    // Reset in cycle 2 of a window kills it without a done pulse
    check_cycle("midrst c0", 0, 8'h00, 1'b1, 1'b0);
    drive(0, 1'b1, 3'd1);
    @(negedge clk);
    check_cycle("midrst c1", 0, 8'h02, QUEUE, 1'b0);
    drive(0, 1'b0, 3'd0);
    @(negedge clk);
    check_cycle("midrst c2", 0, 8'h02, QUEUE, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_cycle("midrst c3", 0, 8'h00, 1'b1, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check_cycle("midrst c4", 0, 8'h00, 1'b1, 1'b0);
    drive(0, 1'b1, 3'd6);
    @(negedge clk);
    drive(0, 1'b0, 3'd0);
    for (int c = 5; c <= 8; c++) begin
      check_cycle($sformatf("midrst c%0d", c), 0, 8'h40, QUEUE, (c == 8));
      @(negedge clk);
    end
    check_cycle("midrst c9", 0, 8'h00, 1'b1, 1'b0);

    run_random(0, 4, 300);
    run_random(1, 1, 300);
    run_random(2, 2, 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
